// File: rtl/quadrature_lo_sequencer.sv
// I/Q local-oscillator sequencer: divides clk by 4*(div+1) and drives
// 50%-duty in-phase/quadrature square waves with selectable sideband.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cfg_valid/ready   configuration handshake (ready = no pending update)
//   cfg_div, cfg_sb   quarter length minus 1, sideband (0 USB, 1 LSB)
//   run               level request to generate the LO
//   out_i, out_q      registered LO outputs
//   running           high while generating or draining to a period end
//   phase             current quarter index 0..3
//   quarter_tick      pulse on the last clk of each quarter
module quadrature_lo_sequencer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_sb,
    input  logic             run,
    output logic             out_i,
    output logic             out_q,
    output logic             running,
    output logic [1:0]       phase,
    output logic             quarter_tick
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       phase_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             out_i_d, out_q_d;
    logic [DIV_W-1:0] act_div_q, act_div_d;
    logic             act_sb_q, act_sb_d;
    logic [DIV_W-1:0] sh_div_q, sh_div_d;
    logic             sh_sb_q, sh_sb_d;
    logic             pend_q, pend_d;
    logic             accept;
    logic             cnt_zero;
    logic             boundary;

    assign cfg_ready    = !pend_q;
    assign running      = (state_q != IDLE);
    assign accept       = cfg_valid && !pend_q;
    assign cnt_zero     = (cnt_q == '0);
    assign quarter_tick = running && cnt_zero;
    assign boundary     = running && cnt_zero && (phase == 2'd3);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase;
        cnt_d     = cnt_q;
        out_i_d   = out_i;
        out_q_d   = out_q;
        act_div_d = act_div_q;
        act_sb_d  = act_sb_q;
        sh_div_d  = sh_div_q;
        sh_sb_d   = sh_sb_q;
        pend_d    = pend_q;

        case (state_q)
            IDLE: begin
                // A config accepted on the start edge already
                // governs the first period, so it is never mixed.
                if (accept) begin
                    act_div_d = cfg_div;
                    act_sb_d  = cfg_sb;
                end
                if (run) begin
                    state_d = RUN;
                    phase_d = 2'd0;
                    cnt_d   = act_div_d;
                    out_i_d = 1'b1;
                    out_q_d = act_sb_d;
                end
            end
            RUN, DRAIN: begin
                state_d = run ? RUN : DRAIN;
                if (boundary && pend_q) begin
                    act_div_d = sh_div_q;
                    act_sb_d  = sh_sb_q;
                    pend_d    = 1'b0;
                end
                if (cnt_zero) begin
                    phase_d = phase + 2'd1;
                    cnt_d   = act_div_d;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                out_i_d = (phase_d == 2'd0) || (phase_d == 2'd1);
                if (act_sb_d) begin
                    out_q_d = (phase_d == 2'd3) || (phase_d == 2'd0);
                end else begin
                    out_q_d = (phase_d == 2'd1) || (phase_d == 2'd2);
                end
                // Stopping only on a period end keeps every pulse whole.
                if (state_q == DRAIN && boundary && !run) begin
                    state_d = IDLE;
                    phase_d = 2'd0;
                    cnt_d   = '0;
                    out_i_d = 1'b0;
                    out_q_d = 1'b0;
                end
                if (accept) begin
                    sh_div_d = cfg_div;
                    sh_sb_d  = cfg_sb;
                    pend_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = 2'd0;
                cnt_d   = '0;
                out_i_d = 1'b0;
                out_q_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            phase     <= 2'd0;
            cnt_q     <= '0;
            out_i     <= 1'b0;
            out_q     <= 1'b0;
            act_div_q <= '0;
            act_sb_q  <= 1'b0;
            sh_div_q  <= '0;
            sh_sb_q   <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase     <= phase_d;
            cnt_q     <= cnt_d;
            out_i     <= out_i_d;
            out_q     <= out_q_d;
            act_div_q <= act_div_d;
            act_sb_q  <= act_sb_d;
            sh_div_q  <= sh_div_d;
            sh_sb_q   <= sh_sb_d;
            pend_q    <= pend_d;
        end
    end

endmodule

// File: tb/tb_quadrature_lo_sequencer.sv
// Bench for quadrature_lo_sequencer: directed scenarios then random
// stimulus, every cycle compared against a period-position model.
module tb_quadrature_lo_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_div;
    logic       cfg_sb;
    logic       run;
    logic       out_i;
    logic       out_q;
    logic       running;
    logic [1:0] phase;
    logic       quarter_tick;

    quadrature_lo_sequencer #(.DIV_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_div      (cfg_div),
        .cfg_sb       (cfg_sb),
        .run          (run),
        .out_i        (out_i),
        .out_q        (out_q),
        .running      (running),
        .phase        (phase),
        .quarter_tick (quarter_tick)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: position within the current LO period plus config state.
    int m_pos;
    int m_div;
    bit m_sb;
    int m_sh_div;
    bit m_sh_sb;
    bit m_pend;
    bit m_run;
    bit m_drain;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_pos    = 0;
        m_div    = 0;
        m_sb     = 0;
        m_sh_div = 0;
        m_sh_sb  = 0;
        m_pend   = 0;
        m_run    = 0;
        m_drain  = 0;
    endfunction

    function automatic void m_edge();
        bit acc;
        bit bnd;
        if (rst) begin
            m_reset();
            return;
        end
        acc = cfg_valid && !m_pend;
        if (!m_run) begin
            if (acc) begin
                m_div = int'(cfg_div);
                m_sb  = cfg_sb;
            end
            if (run) begin
                m_run   = 1;
                m_drain = 0;
                m_pos   = 0;
            end
        end else begin
            bnd = (m_pos == 4 * (m_div + 1) - 1);
            if (bnd && m_pend) begin
                m_div  = m_sh_div;
                m_sb   = m_sh_sb;
                m_pend = 0;
            end
            if (bnd && m_drain && !run) begin
                m_run = 0;
                m_pos = 0;
            end else begin
                m_pos   = bnd ? 0 : m_pos + 1;
                m_drain = !run;
            end
            if (acc) begin
                m_sh_div = int'(cfg_div);
                m_sh_sb  = cfg_sb;
                m_pend   = 1;
            end
        end
    endfunction

    task automatic check_all();
        int q;
        int ph;
        bit e_i;
        bit e_q;
        bit e_t;
        q   = m_div + 1;
        ph  = m_pos / q;
        e_i = m_run && (ph < 2);
        e_q = m_run && (m_sb ? (ph == 3 || ph == 0)
                             : (ph == 1 || ph == 2));
        e_t = m_run && ((m_pos % q) == q - 1);
        chk("out_i", 32'(out_i), 32'(e_i));
        chk("out_q", 32'(out_q), 32'(e_q));
        chk("running", 32'(running), 32'(m_run));
        chk("phase", 32'(phase), m_run ? ph : 0);
        chk("tick", 32'(quarter_tick), 32'(e_t));
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    endtask

    task automatic cyc(input bit r, input bit v,
                       input int d, input bit s);
        run       = r;
        cfg_valid = v;
        cfg_div   = d[7:0];
        cfg_sb    = s;
        @(posedge clk);
        m_edge();
        #1;
        check_all();
    endtask

    task automatic areset();
        #2 rst = 1'b1;
        #1;
        m_reset();
        check_all();
        cyc(1'b0, 1'b0, 0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic idle_out(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 1'b0);
    endtask

    bit rr;
    bit vv;
    int dd;

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;
        cfg_sb    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        check_all();
        rst = 1'b0;

        // Default div=0 USB: clk/4.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 0, 1'b0);
        idle_out(8);

        // div=2 LSB loaded in IDLE.
        cyc(1'b0, 1'b1, 2, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 0, 1'b0);
        // One-cycle run drop mid-period.
        cyc(1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 0, 1'b0);
        // Stop: drain to period end.
        idle_out(20);

        // div=1 run, then retune to div=3 while running.
        cyc(1'b0, 1'b1, 1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 3, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 0, 1'b0);

        // Reset with an update pending.
        cyc(1'b1, 1'b1, 5, 1'b1);
        cyc(1'b1, 1'b0, 0, 1'b0);
        areset();
        idle_out(3);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 0, 1'b0);

        rr = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) rr = !rr;
            vv = ($urandom_range(0, 7) == 0);
            dd = ($urandom_range(0, 59) == 0) ? 255
                                             : int'($urandom_range(0, 4));
            if ($urandom_range(0, 799) == 0) begin
                areset();
            end else begin
                cyc(rr, vv, dd, 1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
